// File: rtl/mult_datapath.sv
// mult_datapath: X:A:B product register and 9-bit add/subtract datapath for
// the signed add-shift multiplier. Sequencing is owned by the external
// controller, which drives the Reset_c / Clr_Ld / Add / Fn / Shift_En strobes.
// M (B[0]) goes back to the controller to drive its next add decision.
//
// Optional feature: define MULT_STEP_CNT_EN to add a saturating 4-bit shift
// counter (StepCnt) and a Done flag that is high while StepCnt >= W.
// W must be 15 or less when the counter is enabled.

module mult_datapath #(
   parameter int W = 8
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Reset_c,
   input  logic         Clr_Ld,
   input  logic         Add,
   input  logic         Fn,
   input  logic         Shift_En,
   input  logic [W-1:0] S,
   output logic         Xval,
   output logic [W-1:0] Aval,
   output logic [W-1:0] Bval,
   output logic         M
`ifdef MULT_STEP_CNT_EN
   ,
   output logic [3:0]   StepCnt,
   output logic         Done
`endif
);

   // Current register state
   logic         x_q;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;

   // Next-state values
   logic         x_d;
   logic [W-1:0] a_d;
   logic [W-1:0] b_d;

   // Adder operands and result, W+1 bits wide so X acts as the sign bit
   logic [W:0]   a_ext;
   logic [W:0]   s_ext;
   logic [W:0]   sum;

   // Sign-extend both operands; Fn selects two's complement negation of S
   always_comb begin
      a_ext = {a_q[W-1], a_q};
      s_ext = {S[W-1], S} ^ {(W+1){Fn}};
      // Carry out of bit W falls off the W+1 bit result on purpose
      sum   = a_ext + s_ext + {{W{1'b0}}, Fn};
   end

   // Next-state selection: Reset_c > Clr_Ld > {Add, Shift_En}
   // NOTE: every output of this block gets a default first (hold), so no
   // path through the if/case leaves a signal unassigned and no latch appears.
   always_comb begin
      x_d = x_q;
      a_d = a_q;
      b_d = b_q;
      if (Reset_c) begin
         x_d = 1'b0;
         a_d = '0;
         b_d = '0;
      end else if (Clr_Ld) begin
         x_d = 1'b0;
         a_d = '0;
         b_d = S;
      end else begin
         unique case ({Add, Shift_En})
            2'b10: begin
               x_d = sum[W];
               a_d = sum[W-1:0];
            end
            2'b01: begin
               a_d = {x_q, a_q[W-1:1]};
               b_d = {a_q[0], b_q[W-1:1]};
            end
            2'b11: begin
               // Add then shift the add result within one cycle
               x_d = sum[W];
               a_d = sum[W:1];
               b_d = {sum[0], b_q[W-1:1]};
            end
            default: ;
         endcase
      end
   end

   // Product register with asynchronous clear
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, which the shift chain relies on.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         x_q <= 1'b0;
         a_q <= '0;
         b_q <= '0;
      end else begin
         x_q <= x_d;
         a_q <= a_d;
         b_q <= b_d;
      end
   end

   // Outputs straight from the registers; M is the multiplier LSB
   always_comb begin
      Xval = x_q;
      Aval = a_q;
      Bval = b_q;
      M    = b_q[0];
   end

`ifdef MULT_STEP_CNT_EN
   logic [3:0] cnt_q;

   // Shift counter: cleared by any clear/load, counts shifts, sticks at 15
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cnt_q <= 4'd0;
      end else if (Reset_c || Clr_Ld) begin
         cnt_q <= 4'd0;
      end else if (Shift_En && (cnt_q != 4'd15)) begin
         cnt_q <= cnt_q + 4'd1;
      end
   end

   // Done is decoded combinationally from the counter
   always_comb begin
      StepCnt = cnt_q;
      Done    = (cnt_q >= 4'(W));
   end
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: table-driven check of mult_datapath. Each vector is one
// clock of strobes plus the hand-derived register state after that edge; the
// expectation is queued when the vector is driven and popped when sampled.
// Hand-written sequences cover async reset and the optional step counter.

module tb_mult_datapath;

   localparam int W = 8;

   logic         Clk = 1'b0;
   logic         Reset;
   logic         Reset_c, Clr_Ld, Add, Fn, Shift_En;
   logic [W-1:0] S;
   logic         Xval, M;
   logic [W-1:0] Aval, Bval;
`ifdef MULT_STEP_CNT_EN
   logic [3:0]   StepCnt;
   logic         Done;
`endif

   mult_datapath #(.W(W)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Reset_c  (Reset_c),
      .Clr_Ld   (Clr_Ld),
      .Add      (Add),
      .Fn       (Fn),
      .Shift_En (Shift_En),
      .S        (S),
      .Xval     (Xval),
      .Aval     (Aval),
      .Bval     (Bval),
      .M        (M)
`ifdef MULT_STEP_CNT_EN
      ,
      .StepCnt  (StepCnt),
      .Done     (Done)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic         rc, cl, ad, fn, sh;
      logic [W-1:0] s;
      logic         ex;
      logic [W-1:0] ea, eb;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rc, cl, ad, fn, sh, input logic [W-1:0] s,
                               input logic ex, input logic [W-1:0] ea, eb);
      vec_t v;
      v.rc = rc; v.cl = cl; v.ad = ad; v.fn = fn; v.sh = sh; v.s = s;
      v.ex = ex; v.ea = ea; v.eb = eb;
      return v;
   endfunction

   task automatic idle();
      Reset_c = 0; Clr_Ld = 0; Add = 0; Fn = 0; Shift_En = 0;
   endtask

   // One clock with the given strobes; inputs change on the falling edge
   task automatic drive(input logic rc, cl, ad, fn, sh, input logic [W-1:0] s);
      @(negedge Clk);
      Reset_c = rc; Clr_Ld = cl; Add = ad; Fn = fn; Shift_En = sh; S = s;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      vec_t v, e;

      //               rc cl ad fn sh  S      X  A      B
      vecs.push_back(mk(0, 0, 1, 0, 0, 8'h80, 1, 8'h80, 8'h00)); // 0-128
      vecs.push_back(mk(0, 0, 1, 0, 0, 8'h92, 1, 8'h12, 8'h00)); // -238 -> X=1,A=12
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'hC5, 0, 8'h00, 8'hC5)); // load
      vecs.push_back(mk(0, 1, 1, 0, 1, 8'h3C, 0, 8'h00, 8'h3C)); // load wins
      vecs.push_back(mk(0, 0, 1, 0, 0, 8'h7F, 0, 8'h7F, 8'h3C));
      vecs.push_back(mk(0, 0, 1, 0, 0, 8'h01, 0, 8'h80, 8'h3C)); // +128 in 9 bits
      vecs.push_back(mk(0, 0, 0, 1, 0, 8'hFF, 0, 8'h80, 8'h3C)); // Fn alone: hold
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'hC5, 0, 8'h00, 8'hC5));
      vecs.push_back(mk(0, 0, 1, 0, 0, 8'h05, 0, 8'h05, 8'hC5));
      vecs.push_back(mk(0, 0, 1, 1, 0, 8'h07, 1, 8'hFE, 8'hC5)); // 5-7=-2
      vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 1, 8'hFF, 8'h62)); // shift, M=0
      vecs.push_back(mk(0, 0, 0, 0, 0, 8'hAA, 1, 8'hFF, 8'h62)); // hold
      vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 1, 8'hFF, 8'hB1)); // shift, M=1
      vecs.push_back(mk(1, 0, 1, 0, 1, 8'h55, 0, 8'h00, 8'h00)); // Reset_c wins
      vecs.push_back(mk(0, 1, 0, 0, 0, 8'h01, 0, 8'h00, 8'h01));
      vecs.push_back(mk(0, 0, 1, 0, 0, 8'h10, 0, 8'h10, 8'h01));
      vecs.push_back(mk(0, 0, 1, 0, 1, 8'h02, 0, 8'h09, 8'h00)); // add+shift
      vecs.push_back(mk(0, 0, 1, 1, 1, 8'h0A, 1, 8'hFF, 8'h80)); // 9-10, shift

      idle();
      S     = '0;
      Reset = 1'b1;
      #12;
      check("reset X", 32'(Xval), 32'd0);
      check("reset A", 32'(Aval), 32'd0);
      check("reset B", 32'(Bval), 32'd0);
      check("reset M", 32'(M), 32'd0);
      @(negedge Clk);
      Reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         @(negedge Clk);
         Reset_c = v.rc; Clr_Ld = v.cl; Add = v.ad; Fn = v.fn; Shift_En = v.sh; S = v.s;
         exp_q.push_back(v);
         @(posedge Clk);
         #1;
         e = exp_q.pop_front();
         check($sformatf("vec%0d X", i), 32'(Xval), 32'(e.ex));
         check($sformatf("vec%0d A", i), 32'(Aval), 32'(e.ea));
         check($sformatf("vec%0d B", i), 32'(Bval), 32'(e.eb));
         check($sformatf("vec%0d M", i), 32'(M),    32'(e.eb[0]));
      end
      @(negedge Clk);
      idle();

      // Asynchronous reset mid-cycle with A=5A, B=33
      drive(0, 1, 0, 0, 0, 8'h33);
      drive(0, 0, 1, 0, 0, 8'h5A);
      @(negedge Clk);
      idle();
      check("pre-reset A", 32'(Aval), 32'h5A);
      check("pre-reset B", 32'(Bval), 32'h33);
      #1;
      Reset = 1'b1;
      #1;
      check("async reset X", 32'(Xval), 32'd0);
      check("async reset A", 32'(Aval), 32'd0);
      check("async reset B", 32'(Bval), 32'd0);
      check("async reset M", 32'(M), 32'd0);
      #1;
      Reset = 1'b0;

      // Held strobe: three consecutive shifts of a loaded value
      drive(0, 1, 0, 0, 0, 8'h96);
      drive(0, 0, 1, 0, 0, 8'h03);      // X=0 A=03 B=96
      drive(0, 0, 0, 0, 1, 8'h00);      // A=01 B=CB
      drive(0, 0, 0, 0, 1, 8'h00);      // A=00 B=E5
      drive(0, 0, 0, 0, 1, 8'h00);      // A=00 B=72
      check("held shift A", 32'(Aval), 32'h00);
      check("held shift B", 32'(Bval), 32'h72);
      check("held shift M", 32'(M), 32'd0);

`ifdef MULT_STEP_CNT_EN
      drive(0, 1, 0, 0, 0, 8'h11);
      check("cnt after load", 32'(StepCnt), 32'd0);
      for (int i = 0; i < 7; i++) drive(0, 0, 0, 0, 1, 8'h00);
      check("cnt 7", 32'(StepCnt), 32'd7);
      check("done at 7", 32'(Done), 32'd0);
      drive(0, 0, 0, 0, 1, 8'h00);
      check("cnt 8", 32'(StepCnt), 32'd8);
      check("done at 8", 32'(Done), 32'd1);
      drive(0, 0, 1, 0, 0, 8'h01);
      check("cnt add no step", 32'(StepCnt), 32'd8);
      for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 1, 8'h00);
      check("cnt saturate", 32'(StepCnt), 32'd15);
      drive(1, 0, 0, 0, 1, 8'h00);
      check("cnt Reset_c", 32'(StepCnt), 32'd0);
      check("done cleared", 32'(Done), 32'd0);
`endif

      @(negedge Clk);
      idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
